// File: rtl/control.sv
// Indexed-gather engine: streams vec[col[i]] into a FWFT FIFO read at HHT_ADDR.
// Optional feature macro: HHT_BOUNDS_CHECK_EN (column range check vs VEC_SIZE).
module control #(
    parameter int HHT_ADDR   = 126,
    parameter int FIFO_DEPTH = 8,
    parameter int VEC_SIZE   = 16
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] wdata_col_base,
    input  logic [31:0] v_values_base,
    input  logic [31:0] csize,
    output logic [31:0] addr1,
    input  logic [31:0] dataIn1,
    output logic [31:0] addr2,
    input  logic [31:0] dataIn2,
    input  logic        RD,
    input  logic [31:0] cpu_addr,
    output logic        hht,
    output logic [31:0] rdata,
    output logic [31:0] adata,
    output logic [31:0] regaddr1,
    output logic [31:0] regaddr2
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, GATHER, DONE} state_t;

    typedef struct packed {
        logic [31:0] val;
        logic [31:0] col;
        logic [31:0] ra1;
        logic [31:0] ra2;
    } entry_t;

    state_t      state, state_nx;
    logic [31:0] col_base, vec_base, csize_r;
    logic [31:0] i, col_reg;
    logic [31:0] addr1_q, addr2_q;

    entry_t      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    logic [31:0] fetch_addr, gather_addr, gather_val;
    logic        full, push, pop, last;
    entry_t      push_entry, head;

    assign fetch_addr = col_base + i;
    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    assign hht        = (count != '0);
    assign push       = (state == GATHER);
    assign pop        = RD && (cpu_addr == 32'(HHT_ADDR)) && hht;
    assign last       = (i + 32'd1 == csize_r);

    // Out-of-range columns leave addr2 at the vector base and gather a zero
    always_comb begin
        gather_addr = vec_base + col_reg;
        gather_val  = dataIn2;
`ifdef HHT_BOUNDS_CHECK_EN
        if (col_reg >= 32'(VEC_SIZE)) begin
            gather_addr = vec_base;
            gather_val  = '0;
        end
`endif
    end

    assign push_entry = '{val: gather_val, col: col_reg,
                          ra1: fetch_addr, ra2: gather_addr};

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = (csize == '0) ? DONE : FETCH;
            FETCH:   if (!full) state_nx = GATHER;
            GATHER:  state_nx = last ? DONE : FETCH;
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        addr1 = (state == FETCH)  ? fetch_addr  : addr1_q;
        addr2 = (state == GATHER) ? gather_addr : addr2_q;
        head  = '0;
        if (hht) head = fifo_mem[rd_ptr];
        rdata    = head.val;
        adata    = head.col;
        regaddr1 = head.ra1;
        regaddr2 = head.ra2;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            col_base <= '0;
            vec_base <= '0;
            csize_r  <= '0;
            i        <= '0;
            col_reg  <= '0;
            addr1_q  <= '0;
            addr2_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    col_base <= wdata_col_base;
                    vec_base <= v_values_base;
                    csize_r  <= csize;
                end
                FETCH: begin
                    addr1_q <= fetch_addr;
                    if (!full) col_reg <= dataIn1;
                end
                GATHER: begin
                    addr2_q <= gather_addr;
                    i       <= i + 32'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (push) fifo_mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

endmodule

// File: tb/tb_control.sv
// Scoreboard bench for control: stimulus queues expected heads, monitor pops them.
module tb_control;

    typedef struct packed {
        logic [31:0] val;
        logic [31:0] col;
        logic [31:0] ra1;
        logic [31:0] ra2;
    } entry_t;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [31:0] wdata_col_base = '0;
    logic [31:0] v_values_base  = '0;
    logic [31:0] csize          = '0;
    logic [31:0] addr1, addr2, dataIn1, dataIn2;
    logic        RD = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic        hht;
    logic [31:0] rdata, adata, regaddr1, regaddr2;

    logic [31:0] mem [0:1023];
    entry_t      q [$];
    int          total = 0;
    int          bad   = 0;

    always #5 Clk = ~Clk;

    assign dataIn1 = (addr1 < 32'd1024) ? mem[addr1[9:0]] : (addr1 ^ 32'h5a5a0000);
    assign dataIn2 = (addr2 < 32'd1024) ? mem[addr2[9:0]] : (addr2 ^ 32'h5a5a0000);

    control dut (
        .Clk(Clk), .Rst(Rst),
        .wdata_col_base(wdata_col_base), .v_values_base(v_values_base),
        .csize(csize),
        .addr1(addr1), .dataIn1(dataIn1),
        .addr2(addr2), .dataIn2(dataIn2),
        .RD(RD), .cpu_addr(cpu_addr),
        .hht(hht), .rdata(rdata), .adata(adata),
        .regaddr1(regaddr1), .regaddr2(regaddr2)
    );

    function automatic logic [31:0] rmem(logic [31:0] a);
        return (a < 32'd1024) ? mem[a[9:0]] : (a ^ 32'h5a5a0000);
    endfunction

    function automatic entry_t model(int j, logic [31:0] cb, logic [31:0] vb);
        entry_t e;
        e.ra1 = cb + 32'(j);
        e.col = rmem(e.ra1);
        e.ra2 = vb + e.col;
        e.val = rmem(e.ra2);
`ifdef HHT_BOUNDS_CHECK_EN
        if (e.col >= 32'd16) begin
            e.ra2 = vb;
            e.val = '0;
        end
`endif
        return e;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every head the CPU actually pops is compared with the queue front
    always @(negedge Clk) begin
        if (!Rst && RD && cpu_addr == 32'd126 && hht) begin
            if (q.size() == 0) begin
                check("unexpected_pop", rdata, 32'hffffffff);
            end else begin
                entry_t e;
                e = q.pop_front();
                check("rdata", rdata, e.val);
                check("adata", adata, e.col);
                check("regaddr1", regaddr1, e.ra1);
                check("regaddr2", regaddr2, e.ra2);
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic setup(logic [31:0] cb, logic [31:0] vb, logic [31:0] n,
                         logic rd, logic [31:0] ca);
        step(1);
        Rst = 1'b1;
        q.delete();
        wdata_col_base = cb;
        v_values_base  = vb;
        csize          = n;
        RD             = rd;
        cpu_addr       = ca;
        step(1);
    endtask

    task automatic drain(int maxc);
        int c = 0;
        while (q.size() != 0 && c < maxc) begin
            step(1);
            c++;
        end
        check("drain_left", 32'(q.size()), 32'd0);
    endtask

    task automatic check_zero_outputs(string tag);
        check({tag, "_hht"}, {31'd0, hht}, 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_adata"}, adata, 32'd0);
        check({tag, "_regaddr1"}, regaddr1, 32'd0);
        check({tag, "_regaddr2"}, regaddr2, 32'd0);
        check({tag, "_addr1"}, addr1, 32'd0);
        check({tag, "_addr2"}, addr2, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        entry_t e;
        bit     seen;
        for (int k = 0; k < 1024; k++) mem[k] = 32'(k) * 32'd3 + 32'd100;
        for (int j = 0; j < 230; j++) mem[180 + j] = 32'((j * 7 + 15) % 16);
        mem[180] = 32'd15; mem[17] = 32'd34;
        mem[181] = 32'd2;  mem[4]  = 32'd68;
        mem[182] = 32'd11; mem[13] = 32'd52;
        mem[500] = 32'd99999;

        @(negedge Clk);
        check_zero_outputs("reset");

        // Full 230-element stream, CPU always reading
        setup(32'd180, 32'd2, 32'd230, 1'b1, 32'd126);
        q.push_back('{32'd34, 32'd15, 32'd180, 32'd17});
        q.push_back('{32'd68, 32'd2, 32'd181, 32'd4});
        q.push_back('{32'd52, 32'd11, 32'd182, 32'd13});
        for (int j = 3; j < 230; j++) q.push_back(model(j, 32'd180, 32'd2));
        e = model(229, 32'd180, 32'd2);
        Rst = 1'b0;
        repeat (3) @(negedge Clk);
        check("lat_hht_early", {31'd0, hht}, 32'd0);
        @(negedge Clk);
        check("lat_hht_on", {31'd0, hht}, 32'd1);
        step(1);
        drain(1200);
        step(3);
        check("done_addr1", addr1, 32'd409);
        check("done_addr2", addr2, e.ra2);
        check("done_hht", {31'd0, hht}, 32'd0);

        // CPU silent: FIFO fills to 8 and the fetch stalls at 188
        setup(32'd180, 32'd2, 32'd230, 1'b0, 32'd126);
        for (int j = 0; j < 230; j++) q.push_back(model(j, 32'd180, 32'd2));
        Rst = 1'b0;
        step(40);
        check("full_hht", {31'd0, hht}, 32'd1);
        check("full_addr1", addr1, 32'd188);
        check("full_head", rdata, 32'd34);
        step(10);
        check("full_hold_addr1", addr1, 32'd188);
        RD = 1'b1;
        drain(1200);

        // Empty job: nothing is ever pushed
        setup(32'd180, 32'd2, 32'd0, 1'b1, 32'd126);
        Rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (hht) seen = 1'b1;
        end
        check("csize0_hht_seen", {31'd0, seen}, 32'd0);
        check("csize0_addr1", addr1, 32'd0);

        // Wrong CPU address: no pops; then reset mid-stream and restart
        setup(32'd180, 32'd2, 32'd5, 1'b1, 32'd125);
        Rst = 1'b0;
        step(20);
        check("wrongaddr_hht", {31'd0, hht}, 32'd1);
        check("wrongaddr_rdata", rdata, 32'd34);
        check("wrongaddr_adata", adata, 32'd15);
        Rst = 1'b1;
        @(negedge Clk);
        check_zero_outputs("midreset");
        step(1);
        cpu_addr = 32'd126;
        for (int j = 0; j < 5; j++) q.push_back(model(j, 32'd180, 32'd2));
        Rst = 1'b0;
        drain(100);

        // Column index far outside the vector range
        setup(32'd500, 32'd2, 32'd1, 1'b0, 32'd126);
        q.push_back(model(0, 32'd500, 32'd2));
        Rst = 1'b0;
        step(10);
        check("oob_adata", adata, 32'd99999);
        check("oob_regaddr1", regaddr1, 32'd500);
`ifdef HHT_BOUNDS_CHECK_EN
        check("oob_addr2", addr2, 32'd2);
        check("oob_rdata", rdata, 32'd0);
`else
        check("oob_addr2", addr2, 32'd100001);
        check("oob_rdata", rdata, 32'd100001 ^ 32'h5a5a0000);
`endif
        RD = 1'b1;
        drain(20);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control.md
CONTROL -- requirements
Module: control

Interface
REQ-001 Parameter HHT_ADDR, default 126: CPU address at which the gathered stream is read.
REQ-002 Parameter FIFO_DEPTH, default 8: gather buffer entries (power of two).
REQ-003 Parameter VEC_SIZE, default 16: valid column-index range 0..VEC_SIZE-1 (range check only).
REQ-004 Clk  in  1  sole clock; all state rises on posedge.
REQ-005 Rst  in  1  asynchronous, active-high reset.
REQ-006 wdata_col_base  in  32  word address of first column index.
REQ-007 v_values_base  in  32  word address of vector element 0.
REQ-008 csize  in  32  number of column indices to process.
REQ-009 addr1  out  32  column-index memory address.
REQ-010 dataIn1  in  32  column index, combinational read of addr1.
REQ-011 addr2  out  32  vector memory address.
REQ-012 dataIn2  in  32  vector value, combinational read of addr2.
REQ-013 RD  in  1  CPU read strobe.
REQ-014 cpu_addr  in  32  CPU read address.
REQ-015 hht  out  1  FIFO head valid.
REQ-016 rdata  out  32  head gathered vector value.
REQ-017 adata  out  32  head column index.
REQ-018 regaddr1  out  32  head's column-index address.
REQ-019 regaddr2  out  32  head's vector address.

Function
REQ-020 FSM states IDLE, FETCH, GATHER, DONE; register i (0..csize) counts processed elements.
REQ-021 IDLE: first posedge with Rst low latches wdata_col_base, v_values_base, csize; goes to DONE if csize==0, else FETCH.
REQ-022 FETCH: addr1 = col_base+i; if FIFO not full, capture dataIn1 into col_reg and go to GATHER; if full, hold FETCH with addr1 unchanged.
REQ-023 GATHER: addr2 = vec_base+col_reg; capture dataIn2; push {dataIn2, col_reg, col_base+i, vec_base+col_reg}; i++; next FETCH, or DONE if i+1==csize.
REQ-024 Throughput: one element per 2 cycles absent stalls; element pushed at end of its GATHER cycle; hht high the following cycle.
REQ-025 DONE is terminal until reset; addr1/addr2 hold last values.
REQ-026 Pop when RD==1 and cpu_addr==HHT_ADDR and hht==1; pop with FIFO empty is ignored (no underflow).
REQ-027 rdata/adata/regaddr1/regaddr2 always show the head entry; zero when empty.
REQ-028 FIFO is first-word-fall-through; pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-029 Simultaneous push and pop: count unchanged, both take effect.
REQ-030 Address arithmetic is 32-bit unsigned modulo 2^32.

Reset
REQ-031 Rst high: state IDLE, i=0, col_reg=0, FIFO empty, all outputs 0, hht=0, regardless of operation in progress.
REQ-032 Rst held high keeps the block in reset; processing restarts from element 0 after release.

Configuration
REQ-033 Macro HHT_BOUNDS_CHECK_EN defined: a column index >= VEC_SIZE produces no addr2 access change (addr2 = vec_base) and pushes value 0 with the raw index in adata.
REQ-034 Macro undefined: no range check; addr2 = vec_base+index for any index.

Verification
REQ-035 col_base=180, vec_base=2, csize=230, RD=1, cpu_addr=126, mem[180]=15, mem[17]=34 -> first head rdata=34, adata=15, regaddr1=180, regaddr2=17, hht=1.
REQ-036 Continuing: mem[181]=2, mem[4]=68 -> second head 68/2/181/4; mem[182]=11, mem[13]=52 -> third head 52/11/182/13.
REQ-037 RD=0 -> exactly 8 pushes (addresses 180..187), FSM holds FETCH with addr1=188, hht=1; RD=1 resumes in order.
REQ-038 csize=0 -> DONE after one cycle, hht never asserts; cpu_addr=125 with RD=1 -> no pops.
REQ-039 Rst pulsed after 5 pushes -> FIFO empty, outputs 0; after release first head again 34/15/180/17.
REQ-040 Column index 99999 (unmapped col memory) -> with HHT_BOUNDS_CHECK_EN rdata=0, adata=99999; without, addr2=100001.
